uart_cmd_parser: RTL and testbench

- Downstream consumer of the 16x-oversampled UART byte receiver.
- Detects each new byte from the receiver's `data`/`data_rdy` pair and assembles fixed 5-byte command frames: SYNC, ADDR, DATA_HI, DATA_LO, CHK.
- Validated frames become a single-cycle register-write strobe into the PID parameter register bank; malformed frames are counted and dropped.
- Runs on the same `clk_in` as the receiver; no CDC.

---
 rtl/uart_defs_pkg.sv | 23 ++
 rtl/uart_rdy_edge.sv | 21 ++
 rtl/uart_cmd_parser.sv | 120 ++++++++++++
 tb/tb_uart_cmd_parser.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs_pkg.sv
// Shared definitions for UART byte consumers: frame state encodings,
// frame geometry, the default sync marker and the frame checksum.
package uart_defs_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DHI  = 3'd2,
    ST_DLO  = 3'd3,
    ST_CHK  = 3'd4
  } parser_state_t;

  localparam int unsigned FRAME_LEN     = 5;
  localparam logic [7:0]  DEF_SYNC_BYTE = 8'hA5;

  // Frame checksum: XOR of the address and both data bytes
  function automatic logic [7:0] frame_chk(input logic [7:0] addr,
                                           input logic [7:0] hi,
                                           input logic [7:0] lo);
    return addr ^ hi ^ lo;
  endfunction

endpackage

// File: rtl/uart_rdy_edge.sv
// Turns the receiver's level data-ready into a single-cycle byte strobe.
// The history flop resets to 1 so that a byte already being presented
// when reset releases is not mistaken for a fresh arrival.
module uart_rdy_edge (
  input  logic clk_in,
  input  logic reset,
  input  logic rdy,
  output logic byte_stb
);

  logic rdy_q;

  // Remember last cycle's ready level for rising-edge detection
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) rdy_q <= 1'b1;
    else       rdy_q <= rdy;
  end

  assign byte_stb = rdy & ~rdy_q;

endmodule

// File: rtl/uart_cmd_parser.sv
// Assembles 5-byte command frames (SYNC, ADDR, DATA_HI, DATA_LO, CHK) from
// the UART receiver and issues one-cycle register-write strobes for valid
// frames; rejected frames pulse frame_err and bump a saturating counter.
// Optional build macro UART_PARSER_TIMEOUT_EN adds an inter-byte gap
// timeout that abandons a stalled partial frame.
module uart_cmd_parser
  import uart_defs_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE   = DEF_SYNC_BYTE,
  parameter int unsigned NUM_REGS    = 8,
  parameter int unsigned TIMEOUT_CYC = 640,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic [7:0]           rx_byte,
  input  logic                 rx_rdy,
  output logic                 wr_en,
  output logic [7:0]           wr_addr,
  output logic [15:0]          wr_data,
  output logic                 frame_err,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 busy
);

  parser_state_t state;
  logic          byte_stb;
  logic [7:0]    addr_q;
  logic [7:0]    hi_q;
  logic [7:0]    lo_q;
  logic          timeout;

  // Saturating increment: the error count sticks at all-ones
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  endfunction

  uart_rdy_edge u_rdy_edge (
    .clk_in   (clk_in),
    .reset    (reset),
    .rdy      (rx_rdy),
    .byte_stb (byte_stb)
  );

`ifdef UART_PARSER_TIMEOUT_EN
  localparam int unsigned GAP_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [GAP_W-1:0] gap_q;

  // A byte arriving on the terminal cycle takes priority over the timeout
  assign timeout = (state != ST_IDLE) && !byte_stb &&
                   (gap_q == GAP_W'(TIMEOUT_CYC - 1));

  // Inter-byte gap counter: runs only inside a frame, restarts per byte
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset)                                        gap_q <= '0;
    else if (byte_stb || timeout || state == ST_IDLE) gap_q <= '0;
    else                                              gap_q <= gap_q + GAP_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  // Frame FSM: walks one state per received byte and registers all outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      err_count <= '0;
      addr_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      wr_en     <= 1'b0;
      frame_err <= 1'b0;
      if (byte_stb) begin
        case (state)
          ST_IDLE: begin
            if (rx_byte == SYNC_BYTE) state <= ST_ADDR;
          end
          ST_ADDR: begin
            addr_q <= rx_byte;
            state  <= ST_DHI;
          end
          ST_DHI: begin
            hi_q  <= rx_byte;
            state <= ST_DLO;
          end
          ST_DLO: begin
            lo_q  <= rx_byte;
            state <= ST_CHK;
          end
          ST_CHK: begin
            if (rx_byte == frame_chk(addr_q, hi_q, lo_q) &&
                32'(addr_q) < NUM_REGS) begin
              wr_en   <= 1'b1;
              wr_addr <= addr_q;
              wr_data <= {hi_q, lo_q};
            end else begin
              frame_err <= 1'b1;
              err_count <= sat_inc(err_count);
            end
            state <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end else if (timeout) begin
        frame_err <= 1'b1;
        err_count <= sat_inc(err_count);
        state     <= ST_IDLE;
      end
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus feeds a byte-stream
// reference model that predicts write / error events into a queue; an
// independent monitor pops and compares whenever the DUT pulses an output.
module tb_uart_cmd_parser;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_rdy  = 1'b0;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic [7:0]  err_count;
  logic        busy;

  int comps = 0;
  int fails = 0;

  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t       expq[$];
  logic [7:0] mbuf[$];
  int         m_err  = 0;
  logic [7:0] m_addr = 8'h00;
  logic [15:0] m_data = 16'h0000;

  uart_cmd_parser dut (
    .clk_in    (clk_in),
    .reset     (reset),
    .rx_byte   (rx_byte),
    .rx_rdy    (rx_rdy),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .err_count (err_count),
    .busy      (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    comps++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: works on the byte stream as a whole. Outside a frame
  // only the sync marker starts collection; every FRAME_LEN collected bytes
  // are judged as one frame.
  task automatic model_error();
    if (m_err < 255) m_err++;
    expq.push_back('{is_wr: 1'b0, addr: m_addr, data: m_data, cnt: 8'(m_err)});
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (mbuf.size() == 0) begin
      if (b == 8'hA5) mbuf.push_back(b);
    end else begin
      mbuf.push_back(b);
      if (mbuf.size() == uart_defs_pkg::FRAME_LEN) begin
        if (mbuf[4] == (mbuf[1] ^ mbuf[2] ^ mbuf[3]) && mbuf[1] < 8) begin
          m_addr = mbuf[1];
          m_data = {mbuf[2], mbuf[3]};
          expq.push_back('{is_wr: 1'b1, addr: m_addr, data: m_data, cnt: 8'(m_err)});
        end else begin
          model_error();
        end
        mbuf.delete();
      end
    end
  endtask

  task automatic model_reset();
    mbuf.delete();
    expq.delete();
    m_err  = 0;
    m_addr = 8'h00;
    m_data = 16'h0000;
  endtask

  // Present one byte with rx_rdy high for `hi` cycles, then low for `lo`
  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    @(posedge clk_in); #1;
    rx_byte = b;
    rx_rdy  = 1'b1;
    model_byte(b);
    repeat (hi) @(posedge clk_in);
    #1 rx_rdy = 1'b0;
    repeat (lo) @(posedge clk_in);
  endtask

  task automatic send_frame(input logic [7:0] s, a, h, l, c);
    send_byte(s, 17, 2);
    send_byte(a, 17, 2);
    send_byte(h, 17, 2);
    send_byte(l, 17, 2);
    send_byte(c, 17, 2);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && expq.size() != 0; i++) @(posedge clk_in);
    check(name, expq.size(), 0);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_wr_en"},     wr_en,     0);
    check({tag, "_frame_err"}, frame_err, 0);
    check({tag, "_wr_addr"},   wr_addr,   0);
    check({tag, "_wr_data"},   wr_data,   0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_busy"},      busy,      0);
  endtask

  // Monitor: every output pulse must match the oldest predicted event
  exp_t e;
  always @(negedge clk_in) begin
    if (!reset) begin
      if (wr_en && frame_err) check("wr_en_and_frame_err", 1, 0);
      if (wr_en || frame_err) begin
        if (expq.size() == 0) begin
          check("unexpected_pulse", {wr_en, frame_err}, 0);
        end else begin
          e = expq.pop_front();
          check("event_is_write", wr_en, e.is_wr);
          check("wr_addr",        wr_addr, e.addr);
          check("wr_data",        wr_data, e.data);
          check("err_count",      err_count, e.cnt);
        end
      end
    end
  end

  logic [7:0] a, h, l, c;

  initial begin
    // Reset state
    #23;
    check_idle_outputs("reset");
    @(negedge clk_in);
    reset = 1'b0;

    // Basic valid frame
    send_frame(8'hA5, 8'h03, 8'h12, 8'h34, 8'h25);
    drain("drain_valid");
    check("err_after_valid", err_count, 0);

    // Bad checksum, then a good frame
    send_frame(8'hA5, 8'h03, 8'h12, 8'h34, 8'h26);
    send_frame(8'hA5, 8'h01, 8'h00, 8'h10, 8'h11);
    drain("drain_badchk");

    // Out-of-range address with correct checksum
    send_frame(8'hA5, 8'h09, 8'h00, 8'h01, 8'h08);
    drain("drain_badaddr");

    // Leading garbage ignored
    send_byte(8'h00, 17, 2);
    send_byte(8'hFF, 17, 2);
    send_frame(8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h64);
    drain("drain_garbage");
    check("err_after_garbage", err_count, 2);

    // Randomized traffic, varying ready pulse widths and gaps
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 4) == 0) send_byte(8'($urandom), $urandom_range(1, 17), $urandom_range(1, 4));
      a = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(8, 255)) : 8'($urandom_range(0, 7));
      h = 8'($urandom);
      l = 8'($urandom);
      c = a ^ h ^ l;
      if ($urandom_range(0, 3) == 0) c = c ^ 8'($urandom_range(1, 255));
      send_byte(8'hA5, $urandom_range(1, 17), $urandom_range(1, 4));
      send_byte(a,     $urandom_range(1, 17), $urandom_range(1, 4));
      send_byte(h,     $urandom_range(1, 17), $urandom_range(1, 4));
      send_byte(l,     $urandom_range(1, 17), $urandom_range(1, 4));
      send_byte(c,     $urandom_range(1, 17), $urandom_range(1, 4));
    end
    while (mbuf.size() != 0) send_byte(8'h00, 3, 2);
    drain("drain_random");
    check("busy_after_random", busy, 0);

    // Long gap inside a frame
    send_byte(8'hA5, 17, 2);
    send_byte(8'h03, 17, 2);
`ifdef UART_PARSER_TIMEOUT_EN
    model_error();
    mbuf.delete();
    repeat (700) @(posedge clk_in);
    #1 check("busy_after_timeout", busy, 0);
    drain("drain_timeout");
`else
    repeat (700) @(posedge clk_in);
    #1 check("busy_held_no_timeout", busy, 1);
`endif
    send_byte(8'h12, 17, 2);
    send_byte(8'h34, 17, 2);
    send_byte(8'h25, 17, 2);
    drain("drain_after_gap");

    // Drive the error counter into saturation
    for (int i = 0; i < 260; i++) begin
      send_byte(8'hA5, 2, 1);
      send_byte(8'h0F, 2, 1);
      send_byte(8'h00, 2, 1);
      send_byte(8'h00, 2, 1);
      send_byte(8'h0F, 2, 1);
    end
    drain("drain_saturate");
    check("err_saturated", err_count, 8'hFF);

    // Reset mid-frame, released while a sync byte is still presented
    send_byte(8'hA5, 17, 2);
    send_byte(8'h03, 17, 2);
    @(posedge clk_in); #1;
    reset = 1'b1;
    model_reset();
    #1 check_idle_outputs("midreset");
    rx_byte = 8'hA5;
    rx_rdy  = 1'b1;
    repeat (3) @(posedge clk_in);
    #1 reset = 1'b0;
    repeat (17) @(posedge clk_in);
    #1 rx_rdy = 1'b0;
    repeat (2) @(posedge clk_in);
    check("busy_after_release", busy, 0);
    send_frame(8'hA5, 8'h05, 8'hBE, 8'hEF, 8'h05 ^ 8'hBE ^ 8'hEF);
    drain("drain_post_reset");
    check("err_post_reset", err_count, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", comps, fails);
    $finish;
  end

  // Absolute time guard
  initial begin
    #5ms;
    $display("FAIL timeout_guard: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
